// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle add/sub/logic/shift, iterative multiply and divide.
// Divider (ops 9/10) is built only when ALU_MC_DIV_EN is defined; otherwise those ops yield zero.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] tr,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] dr,
    output logic             sf,
    output logic             zf,
    output logic             cf,
    output logic             vf,
    output logic             flag_up
);
    // state | meaning
    // IDLE  | ready; single-cycle ops complete here
    // ITER  | one multiply/divide bit per cycle, not ready
    // DONE  | iterative result presented, ready for next request
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;
`endif

    state_t state_q, state_n;
    logic accept, is_multi;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc_q, lo_q, opd_q;
    logic [SHW-1:0]   cnt_q;

    always_comb begin
        is_multi = (op == OP_MUL);
`ifdef ALU_MC_DIV_EN
        if (op == OP_DIVU || op == OP_REMU) is_multi = 1'b1;
`endif
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept && is_multi) state_n = S_ITER;
            end
            S_ITER: begin
                if (cnt_q == '0) state_n = S_DONE;
            end
            S_DONE: begin
                in_ready = 1'b1;
                state_n  = (accept && is_multi) ? S_ITER : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Single-cycle datapath; shifts carry one extra bit so the last bit shifted out lands in cf.
    logic [WIDTH:0]        sum, diff, sll_x, srl_x;
    logic signed [WIDTH:0] sra_x;
    logic [WIDTH-1:0]      res_d;
    logic                  cf_d, vf_d, fu_d;

    always_comb begin
        sum   = {1'b0, tr} + {1'b0, sr};
        diff  = {1'b0, tr} - {1'b0, sr};
        sll_x = {1'b0, tr} << shamt;
        srl_x = {tr, 1'b0} >> shamt;
        sra_x = $signed({tr, 1'b0}) >>> shamt;
        res_d = '0;
        cf_d  = 1'b0;
        vf_d  = 1'b0;
        fu_d  = 1'b1;
        case (op)
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                cf_d  = sum[WIDTH];
                vf_d  = (tr[WIDTH-1] == sr[WIDTH-1]) && (sum[WIDTH-1] != tr[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff[WIDTH-1:0];
                cf_d  = diff[WIDTH];
                vf_d  = (tr[WIDTH-1] != sr[WIDTH-1]) && (diff[WIDTH-1] != tr[WIDTH-1]);
            end
            OP_AND: res_d = tr & sr;
            OP_OR:  res_d = tr | sr;
            OP_XOR: res_d = tr ^ sr;
            OP_SLL: {cf_d, res_d} = sll_x;
            OP_SRL: {res_d, cf_d} = srl_x;
            OP_SRA: {res_d, cf_d} = sra_x;
            default: fu_d = 1'b0;
        endcase
    end

    // Right-shifting shift-add multiplier: {acc_q, lo_q} holds the partial product.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cf, fin_vf;

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef ALU_MC_DIV_EN
    // Restoring divider: acc_q is the partial remainder, lo_q shifts dividend out and quotient in.
    logic [WIDTH:0]   div_sh;
    logic             div_ok;
    logic [WIDTH-1:0] div_r_n, div_q_n;

    always_comb begin
        div_sh  = {acc_q, lo_q[WIDTH-1]};
        div_ok  = (div_sh >= {1'b0, opd_q});
        div_r_n = div_ok ? (div_sh[WIDTH-1:0] - opd_q) : div_sh[WIDTH-1:0];
        div_q_n = {lo_q[WIDTH-2:0], div_ok};
    end
`endif

    always_comb begin
        fin_res = mul_lo_n;
        fin_cf  = |mul_hi_n;
        fin_vf  = |mul_hi_n;
`ifdef ALU_MC_DIV_EN
        if (op_q != OP_MUL) begin
            fin_res = (op_q == OP_DIVU) ? div_q_n : div_r_n;
            fin_cf  = 1'b0;
            fin_vf  = (opd_q == '0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            opd_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            dr        <= '0;
            sf        <= 1'b0;
            zf        <= 1'b0;
            cf        <= 1'b0;
            vf        <= 1'b0;
            flag_up   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (is_multi) begin
                    op_q  <= op;
                    acc_q <= '0;
                    lo_q  <= tr;
                    opd_q <= sr;
                    cnt_q <= SHW'(WIDTH - 1);
                end else begin
                    out_valid <= 1'b1;
                    dr        <= res_d;
                    sf        <= res_d[WIDTH-1];
                    zf        <= (res_d == '0);
                    cf        <= cf_d;
                    vf        <= vf_d;
                    flag_up   <= fu_d;
                end
            end
            if (state_q == S_ITER) begin
                if (op_q == OP_MUL) begin
                    acc_q <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                end
`ifdef ALU_MC_DIV_EN
                else begin
                    acc_q <= div_r_n;
                    lo_q  <= div_q_n;
                end
`endif
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    dr        <= fin_res;
                    sf        <= fin_res[WIDTH-1];
                    zf        <= (fin_res == '0);
                    cf        <= fin_cf;
                    vf        <= fin_vf;
                    flag_up   <= 1'b1;
                end
            end
        end
    end
endmodule
